// File: rtl/alu_result_checker_pkg.sv
// Shared widths, depths and state encoding for the ALU result checker.
package alu_result_checker_pkg;

    localparam int DSIZE     = 16;
    localparam int EXP_DEPTH = 8;
    localparam int LOG_DEPTH = 4;
    localparam int TS_W      = 16;
    localparam int LOG_W     = TS_W + 2 * DSIZE;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Counters stick at all-ones so a long run never wraps back to a small count.
    function automatic logic [TS_W-1:0] sat_inc(input logic [TS_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/alu_result_checker_sync_fifo.sv
// Synchronous FIFO with combinational head; clear wins over push/pop, push accepted when full only with a same-edge pop.
module alu_result_checker_sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_result_checker.sv
// Compares every ALU result change against the next golden value; counts and logs mismatches.
//  state  | meaning
//  S_IDLE | after reset, waiting for start
//  S_RUN  | checking alu_out changes, ts running
//  S_DONE | checking finished, results held until next start
module alu_result_checker
    import alu_result_checker_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              exp_wr_en,
    input  logic [DSIZE-1:0]  exp_wr_data,
    output logic              exp_full,
    input  logic [DSIZE-1:0]  alu_out,
    input  logic              log_rd_en,
    output logic [LOG_W-1:0]  log_rd_data,
    output logic              log_empty,
    output logic [TS_W-1:0]   chk_count,
    output logic [TS_W-1:0]   err_count,
    output logic [2:0]        flags,
    output logic              busy
);

    state_t            state;
    logic [DSIZE-1:0]  out_q;
    logic [DSIZE-1:0]  exp_head;
    logic [TS_W-1:0]   ts;
    logic              first;
    logic              exp_empty;
    logic              log_full;
    logic              log_ovf;
    logic              exp_ovf;
    logic              exp_unf;
    logic              start_clr;
    logic              evt;
    logic              exp_pop;
    logic              mismatch;
    logic              exp_drop;
    logic              log_drop;

    assign flags     = {log_ovf, exp_ovf, exp_unf};
    assign start_clr = start && (state != S_RUN);
    assign evt       = (state == S_RUN) && (first || (alu_out != out_q));
    assign exp_pop   = evt && !exp_empty;
    assign mismatch  = exp_pop && (alu_out != exp_head);
    assign exp_drop  = exp_wr_en && exp_full && !exp_pop && !start_clr;
    assign log_drop  = mismatch && log_full && !log_rd_en;

    alu_result_checker_sync_fifo #(.W(DSIZE), .DEPTH(EXP_DEPTH)) u_exp_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (start_clr),
        .push  (exp_wr_en),
        .pop   (exp_pop),
        .din   (exp_wr_data),
        .head  (exp_head),
        .full  (exp_full),
        .empty (exp_empty)
    );

    alu_result_checker_sync_fifo #(.W(LOG_W), .DEPTH(LOG_DEPTH)) u_log_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (start_clr),
        .push  (mismatch),
        .pop   (log_rd_en),
        .din   ({ts, alu_out, exp_head}),
        .head  (log_rd_data),
        .full  (log_full),
        .empty (log_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            out_q     <= '0;
            first     <= 1'b0;
            ts        <= '0;
            chk_count <= '0;
            err_count <= '0;
            log_ovf   <= 1'b0;
            exp_ovf   <= 1'b0;
            exp_unf   <= 1'b0;
        end else begin
            if (exp_drop) exp_ovf <= 1'b1;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state     <= S_RUN;
                        busy      <= 1'b1;
                        first     <= 1'b1;
                        ts        <= '0;
                        chk_count <= '0;
                        err_count <= '0;
                        log_ovf   <= 1'b0;
                        exp_ovf   <= 1'b0;
                        exp_unf   <= 1'b0;
                    end
                end
                S_RUN: begin
                    out_q <= alu_out;
                    first <= 1'b0;
                    ts    <= ts + 1'b1;
                    if (evt) begin
                        if (exp_empty) begin
                            exp_unf <= 1'b1;
                        end else begin
                            chk_count <= sat_inc(chk_count);
                            if (mismatch) err_count <= sat_inc(err_count);
                            if (log_drop) log_ovf <= 1'b1;
                        end
                    end
                    // An event on the stop edge is still processed above.
                    if (stop) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_result_checker.sv
// Scoreboard bench for alu_result_checker: golden values and expected log entries are queued as stimulus is driven.
module tb_alu_result_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic        exp_wr_en;
    logic [15:0] exp_wr_data;
    logic        exp_full;
    logic [15:0] alu_out;
    logic        log_rd_en;
    logic [47:0] log_rd_data;
    logic        log_empty;
    logic [15:0] chk_count;
    logic [15:0] err_count;
    logic [2:0]  flags;
    logic        busy;

    int n_cmp = 0;
    int n_mis = 0;

    logic [15:0] exp_q [$];
    logic [47:0] log_q [$];
    bit          m_run;
    bit          m_first;
    bit          m_unf;
    bit          m_eovf;
    bit          m_lovf;
    logic [15:0] m_outq;
    logic [15:0] m_ts;
    logic [15:0] m_chk;
    logic [15:0] m_err;

    alu_result_checker dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .exp_wr_en   (exp_wr_en),
        .exp_wr_data (exp_wr_data),
        .exp_full    (exp_full),
        .alu_out     (alu_out),
        .log_rd_en   (log_rd_en),
        .log_rd_data (log_rd_data),
        .log_empty   (log_empty),
        .chk_count   (chk_count),
        .err_count   (err_count),
        .flags       (flags),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] sat16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        log_q.delete();
        m_run = 0; m_first = 0; m_unf = 0; m_eovf = 0; m_lovf = 0;
        m_outq = '0; m_ts = '0; m_chk = '0; m_err = '0;
    endtask

    // Behaviour of one clock edge given the inputs that were stable at it.
    task automatic model_step();
        logic [15:0] e;
        if (start && !m_run) begin
            exp_q.delete();
            log_q.delete();
            m_chk = 0; m_err = 0; m_unf = 0; m_eovf = 0; m_lovf = 0;
            m_ts = 0; m_first = 1; m_run = 1;
            return;
        end
        if (log_rd_en && log_q.size() > 0) log_q.delete(0);
        if (m_run) begin
            if (m_first || alu_out != m_outq) begin
                if (exp_q.size() == 0) begin
                    m_unf = 1;
                end else begin
                    e = exp_q[0];
                    exp_q.delete(0);
                    m_chk = sat16(m_chk);
                    if (alu_out != e) begin
                        m_err = sat16(m_err);
                        if (log_q.size() < 4) log_q.push_back({m_ts, alu_out, e});
                        else m_lovf = 1;
                    end
                end
            end
            m_outq  = alu_out;
            m_first = 0;
            m_ts    = m_ts + 16'd1;
            if (stop) m_run = 0;
        end
        if (exp_wr_en) begin
            if (exp_q.size() < 8) exp_q.push_back(exp_wr_data);
            else m_eovf = 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check_state(input string tag);
        check_eq({tag, "_chk"},   64'(chk_count), 64'(m_chk));
        check_eq({tag, "_err"},   64'(err_count), 64'(m_err));
        check_eq({tag, "_flags"}, 64'(flags),     64'({m_lovf, m_eovf, m_unf}));
        check_eq({tag, "_busy"},  64'(busy),      64'(m_run));
        check_eq({tag, "_full"},  64'(exp_full),  64'(exp_q.size() == 8));
        check_eq({tag, "_lempty"}, 64'(log_empty), 64'(log_q.size() == 0));
    endtask

    task automatic push_exp(input logic [15:0] v);
        exp_wr_en   = 1'b1;
        exp_wr_data = v;
        tick();
        exp_wr_en   = 1'b0;
    endtask

    task automatic drive_alu(input logic [15:0] v, input int n);
        alu_out = v;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic read_log(input string tag);
        check_eq({tag, "_lempty"}, 64'(log_empty), 64'(log_q.size() == 0));
        if (log_q.size() > 0) check_eq({tag, "_ldata"}, 64'(log_rd_data), 64'(log_q[0]));
        log_rd_en = 1'b1;
        tick();
        log_rd_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 0; stop = 0; exp_wr_en = 0; exp_wr_data = '0;
        alu_out = '0; log_rd_en = 0;
        model_reset();
        #12;
        check_eq("rst_chk",   64'(chk_count),   64'd0);
        check_eq("rst_err",   64'(err_count),   64'd0);
        check_eq("rst_flags", 64'(flags),       64'd0);
        check_eq("rst_busy",  64'(busy),        64'd0);
        check_eq("rst_full",  64'(exp_full),    64'd0);
        check_eq("rst_lempty", 64'(log_empty),  64'd1);
        check_eq("rst_ldata", 64'(log_rd_data), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Match run: the start edge clears the FIFO, so the first-edge check underflows.
        alu_out = 16'h0000;
        do_start();
        check_eq("match_busy", 64'(busy), 64'd1);
        tick();
        push_exp(16'd5);
        push_exp(16'd9);
        push_exp(16'd3);
        drive_alu(16'd5, 2);
        drive_alu(16'd9, 2);
        drive_alu(16'd3, 2);
        check_state("match");
        check_eq("match_chk3", 64'(chk_count), 64'd3);
        check_eq("match_err0", 64'(err_count), 64'd0);
        check_eq("match_lempty1", 64'(log_empty), 64'd1);
        do_stop();

        // Mismatch logged as {ts, got, exp}.
        do_start();
        tick();
        push_exp(16'h0004);
        push_exp(16'h00FF);
        drive_alu(16'h0004, 1);
        drive_alu(16'h00FE, 2);
        check_state("mism");
        check_eq("mism_err1", 64'(err_count), 64'd1);
        check_eq("mism_fields", 64'(log_rd_data[31:0]), 64'h00FE_00FF);
        read_log("mism_rd");
        check_eq("mism_after_rd", 64'(log_empty), 64'd1);
        do_stop();

        // Underflow: changes with an empty expected FIFO.
        alu_out = 16'h0077;
        do_start();
        tick();
        drive_alu(16'h0078, 1);
        check_state("unf");
        check_eq("unf_flag", 64'(flags[0]), 64'd1);
        check_eq("unf_chk0", 64'(chk_count), 64'd0);
        do_stop();
        check_eq("unf_done_busy", 64'(busy), 64'd0);

        // Overflow of both FIFOs.
        do_start();
        tick();
        for (int i = 0; i < 9; i++) push_exp(16'h0100 + 16'(i));
        check_eq("eovf_full", 64'(exp_full), 64'd1);
        check_eq("eovf_flag", 64'(flags[1]), 64'd1);
        check_state("eovf");
        for (int i = 0; i < 5; i++) drive_alu(16'h0200 + 16'(i), 1);
        check_eq("lovf_err5", 64'(err_count), 64'd5);
        check_eq("lovf_flag", 64'(flags[2]), 64'd1);
        check_state("lovf");
        for (int i = 0; i < 4; i++) read_log("lovf_rd");
        check_eq("lovf_drained", 64'(log_empty), 64'd1);
        log_rd_en = 1'b1;
        tick();
        log_rd_en = 1'b0;
        check_state("lovf_extra_rd");
        do_stop();

        // Stop and change on the same edge; later changes ignored; start clears.
        do_start();
        tick();
        push_exp(16'h0011);
        push_exp(16'h0022);
        drive_alu(16'h0011, 1);
        stop = 1'b1;
        drive_alu(16'h0023, 1);
        stop = 1'b0;
        check_eq("stop_chk2", 64'(chk_count), 64'd2);
        check_eq("stop_err1", 64'(err_count), 64'd1);
        check_eq("stop_busy0", 64'(busy), 64'd0);
        drive_alu(16'h0044, 1);
        drive_alu(16'h0022, 1);
        push_exp(16'h0055);
        check_state("done_ignore");
        check_eq("done_chk2", 64'(chk_count), 64'd2);
        do_start();
        check_state("restart");
        check_eq("restart_flags0", 64'(flags), 64'd0);
        check_eq("restart_lempty", 64'(log_empty), 64'd1);

        // Asynchronous reset in the middle of a run.
        tick();
        push_exp(16'h0066);
        drive_alu(16'h0067, 1);
        check_state("pre_rst");
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_eq("arst_chk",    64'(chk_count), 64'd0);
        check_eq("arst_err",    64'(err_count), 64'd0);
        check_eq("arst_flags",  64'(flags),     64'd0);
        check_eq("arst_busy",   64'(busy),      64'd0);
        check_eq("arst_lempty", 64'(log_empty), 64'd1);
        check_eq("arst_full",   64'(exp_full),  64'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check_state("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
